// File: rtl/la_uart_dumper_pkg.sv
// Shared definitions for the logic-analyzer UART dumper: UART framing constants
// and the readout FSM state encoding.
package la_pkg;

  localparam logic UART_START      = 1'b0;
  localparam logic UART_STOP       = 1'b1;
  localparam int   UART_FRAME_BITS = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_ADDR,
    ST_WAIT,
    ST_LOAD,
    ST_SEND,
    ST_NEXT
  } la_state_e;

endpackage

// File: rtl/la_uart_dumper_if.sv
// Capture-buffer read port: the dumper drives the address, the buffer answers
// with the word one cycle later.
interface la_uart_dumper_if #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 128
);

  logic [ADDR_WIDTH-1:0] read_addr;
  logic [DATA_WIDTH-1:0] read_data;

  modport master (output read_addr, input  read_data);
  modport slave  (input  read_addr, output read_data);

endinterface

// File: rtl/la_uart_dumper_uart_tx_byte.sv
// 8N1 UART byte transmitter. Frames are shifted out LSB first from a 10-bit
// shift register holding {stop, data, start}.
module uart_tx_byte
  import la_pkg::*;
#(
  parameter int CLKS_PER_BIT = 347
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       ready
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = $clog2(UART_FRAME_BITS);

  logic                       active_q, active_d;
  logic [BAUD_W-1:0]          baud_q, baud_d;
  logic [BIT_W-1:0]           bit_q, bit_d;
  logic [UART_FRAME_BITS-1:0] shift_q, shift_d;
  logic                       bit_end;
  logic                       last_cycle;

  assign bit_end    = active_q && (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
  assign last_cycle = bit_end && (bit_q == BIT_W'(UART_FRAME_BITS - 1));

  // Ready already in the final stop-bit cycle so a new start chains with no gap.
  assign ready = !active_q || last_cycle;
  assign tx    = active_q ? shift_q[0] : UART_STOP;

  always_comb begin
    active_d = active_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;

    if (active_q) begin
      if (bit_end) begin
        baud_d  = '0;
        bit_d   = bit_q + 1'b1;
        shift_d = {UART_STOP, shift_q[UART_FRAME_BITS-1:1]};
        if (last_cycle) begin
          active_d = 1'b0;
        end
      end else begin
        baud_d = baud_q + 1'b1;
      end
    end

    if (start && ready) begin
      active_d = 1'b1;
      baud_d   = '0;
      bit_d    = '0;
      shift_d  = {UART_STOP, data, UART_START};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= {UART_FRAME_BITS{UART_STOP}};
    end else begin
      active_q <= active_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
    end
  end

endmodule

// File: rtl/la_uart_dumper.sv
// Capture-buffer readout engine: on a rising edge of done, sends SYNC_BYTE and
// then every buffer word MSB byte first over an 8N1 UART line.
module la_uart_dumper
  import la_pkg::*;
#(
  parameter int         DATA_WIDTH   = 128,
  parameter int         ADDR_WIDTH   = 9,
  parameter int         DEPTH        = 512,
  parameter int         CLKS_PER_BIT = 347,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   done,
  la_uart_dumper_if.master       mem,
  output logic                   uart_tx,
  output logic                   busy
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int CNT_W  = $clog2(NBYTES + 1);

  la_state_e             state_q, state_d;
  logic                  done_q;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  done_rise;
  logic                  tx_start;
  logic [7:0]            tx_data;
  logic                  tx_ready;

  assign done_rise     = done && !done_q;
  assign busy          = (state_q != ST_IDLE);
  assign mem.read_addr = idx_q;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    word_d   = word_q;
    cnt_d    = cnt_q;
    tx_start = 1'b0;
    tx_data  = word_q[DATA_WIDTH-1 -: 8];

    case (state_q)
      ST_IDLE: begin
        if (done_rise) begin
          tx_start = 1'b1;
          tx_data  = SYNC_BYTE;
          state_d  = ST_SYNC;
        end
      end
      ST_SYNC: begin
        if (tx_ready) begin
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: state_d = ST_WAIT;
      ST_WAIT: state_d = ST_LOAD;
      // The first byte goes straight from the buffer; the rest come from word_q.
      ST_LOAD: begin
        tx_start = 1'b1;
        tx_data  = mem.read_data[DATA_WIDTH-1 -: 8];
        word_d   = mem.read_data << 8;
        cnt_d    = CNT_W'(1);
        state_d  = ST_SEND;
      end
      ST_SEND: begin
        if (cnt_q == CNT_W'(NBYTES)) begin
          state_d = ST_NEXT;
        end else if (tx_ready) begin
          tx_start = 1'b1;
          word_d   = word_q << 8;
          cnt_d    = cnt_q + 1'b1;
        end
      end
      ST_NEXT: begin
        if (tx_ready) begin
          if (idx_q == ADDR_WIDTH'(DEPTH - 1)) begin
            idx_d   = '0;
            state_d = ST_IDLE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_ADDR;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
      idx_q   <= '0;
      word_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done;
      idx_q   <= idx_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk  (clk),
    .rst_n(rst_n),
    .start(tx_start),
    .data (tx_data),
    .tx   (uart_tx),
    .ready(tx_ready)
  );

endmodule

// File: tb/tb_la_uart_dumper.sv
// Directed bench for la_uart_dumper: a 1-cycle-latency RAM model, a cycle-exact
// UART decoder, and a linear sequence of dump scenarios.
module tb_la_uart_dumper;

  localparam int DW    = 32;
  localparam int AW    = 3;
  localparam int DEPTH = 4;
  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;
  localparam int NB    = 1 + DEPTH * DW / 8;

  logic clk;
  logic rst_n;
  logic done;
  logic uart_tx;
  logic busy;

  la_uart_dumper_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem_if ();

  la_uart_dumper #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .DEPTH       (DEPTH),
    .CLKS_PER_BIT(CPB),
    .SYNC_BYTE   (8'hA5)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .done   (done),
    .mem    (mem_if),
    .uart_tx(uart_tx),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ram_word(input logic [AW-1:0] a);
    return 32'h00010203 * (32'(a) + 32'd1);
  endfunction

  always @(posedge clk) mem_if.read_data <= ram_word(mem_if.read_addr);

  int checks = 0;
  int errors = 0;

  // UART decoder state, sampled once per cycle on the falling edge.
  int         cyc_count = 0;
  bit         mon_active = 0;
  int         mon_off = 0;
  int         bit_idx = 0;
  logic [9:0] mon_frame = '1;
  int         n_frames = 0;
  int         frame_errs = 0;
  int         glitch_errs = 0;
  int         last_end = 0;
  bit         have_last = 0;
  int         first_t0 = 0;
  int         busy_rise_cyc = 0;
  int         busy_fall_cyc = 0;
  bit         prev_busy = 0;
  logic [7:0] rx_bytes[$];
  int         gaps[$];
  logic [7:0] exp_bytes[$];

  always @(negedge clk) begin
    cyc_count++;
    if (busy === 1'b1 && !prev_busy) busy_rise_cyc = cyc_count;
    if (busy === 1'b0 && prev_busy) busy_fall_cyc = cyc_count;
    prev_busy = (busy === 1'b1);
    if (rst_n !== 1'b1) begin
      mon_active = 0;
    end else begin
      if (!mon_active && uart_tx === 1'b0) begin
        mon_active = 1;
        mon_off    = 0;
        mon_frame  = '1;
        if (n_frames == 0) first_t0 = cyc_count;
        if (have_last) gaps.push_back(cyc_count - last_end - 1);
      end
      if (mon_active) begin
        bit_idx = mon_off / CPB;
        if (mon_off % CPB == 0) mon_frame[bit_idx] = uart_tx;
        else if (uart_tx !== mon_frame[bit_idx]) glitch_errs++;
        if (mon_off == FRAME - 1) begin
          mon_active = 0;
          last_end   = cyc_count;
          have_last  = 1;
          if (mon_frame[0] !== 1'b0 || mon_frame[9] !== 1'b1) frame_errs++;
          rx_bytes.push_back(mon_frame[8:1]);
          n_frames++;
        end else begin
          mon_off++;
        end
      end
    end
  end

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic clear_monitor();
    rx_bytes.delete();
    gaps.delete();
    mon_active  = 0;
    have_last   = 0;
    n_frames    = 0;
    frame_errs  = 0;
    glitch_errs = 0;
  endtask

  task automatic wait_busy(input logic level, input int limit);
    int k = 0;
    while (busy !== level && k < limit) begin
      @(negedge clk);
      k++;
    end
    if (busy !== level) check_output("timeout_busy", 32'(busy), 32'(level));
  endtask

  task automatic wait_frames(input int n, input int limit);
    int k = 0;
    while (n_frames < n && k < limit) begin
      @(negedge clk);
      k++;
    end
    if (n_frames < n) check_output("timeout_frames", n_frames, n);
  endtask

  task automatic check_dump(input string pfx, input bit with_timing);
    check_output({pfx, "_nbytes"}, rx_bytes.size(), NB);
    check_output({pfx, "_frame_errs"}, frame_errs, 0);
    check_output({pfx, "_glitch_errs"}, glitch_errs, 0);
    for (int i = 0; i < NB; i++) begin
      check_output($sformatf("%s_byte%0d", pfx, i),
                   (i < rx_bytes.size()) ? {24'h0, rx_bytes[i]} : 32'hFFFF_FFFF,
                   {24'h0, exp_bytes[i]});
    end
    if (with_timing) begin
      for (int f = 0; f < NB - 1; f++) begin
        check_output($sformatf("%s_gap%0d", pfx, f),
                     (f < gaps.size()) ? gaps[f] : -1,
                     (f % (DW / 8) == 0) ? 3 : 0);
      end
      check_output({pfx, "_busy_rise_vs_start"}, busy_rise_cyc, first_t0);
      check_output({pfx, "_busy_fall"}, busy_fall_cyc, last_end + 1);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation did not end");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    logic [31:0] w;
    exp_bytes.push_back(8'hA5);
    for (int a = 0; a < DEPTH; a++) begin
      w = 32'h00010203 * (a + 1);
      for (int b = 3; b >= 0; b--) exp_bytes.push_back(w[8*b +: 8]);
    end

    // Reset values, with done already high through reset release.
    rst_n = 1'b0;
    done  = 1'b1;
    repeat (3) @(negedge clk);
    check_output("rst_read_addr", 32'(mem_if.read_addr), 0);
    check_output("rst_uart_tx", 32'(uart_tx), 1);
    check_output("rst_busy", 32'(busy), 0);
    clear_monitor();
    rst_n = 1'b1;
    wait_busy(1'b1, 10);
    wait_busy(1'b0, 1500);
    repeat (2) @(negedge clk);
    check_dump("full", 1'b1);
    check_output("full_idle_addr", 32'(mem_if.read_addr), 0);
    repeat (100) @(negedge clk);
    check_output("held_done_no_redump", n_frames, NB);
    check_output("held_done_busy", 32'(busy), 0);

    // Fresh trigger, done dropped during word 1 and re-raised while busy.
    done = 1'b0;
    repeat (3) @(negedge clk);
    clear_monitor();
    done = 1'b1;
    wait_busy(1'b1, 10);
    wait_frames(6, 500);
    done = 1'b0;
    repeat (20) @(negedge clk);
    done = 1'b1;
    wait_busy(1'b0, 1500);
    repeat (2) @(negedge clk);
    check_dump("drop", 1'b0);
    repeat (100) @(negedge clk);
    check_output("busy_edge_ignored", n_frames, NB);

    // Asynchronous reset in the middle of word 2.
    done = 1'b0;
    repeat (3) @(negedge clk);
    clear_monitor();
    done = 1'b1;
    wait_busy(1'b1, 10);
    wait_frames(10, 800);
    repeat (6) @(negedge clk);
    #2;
    check_output("mid_read_addr", 32'(mem_if.read_addr), 2);
    check_output("mid_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    check_output("async_rst_uart_tx", 32'(uart_tx), 1);
    check_output("async_rst_busy", 32'(busy), 0);
    check_output("async_rst_read_addr", 32'(mem_if.read_addr), 0);
    done = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    clear_monitor();
    done = 1'b1;
    wait_busy(1'b1, 10);
    wait_busy(1'b0, 1500);
    repeat (2) @(negedge clk);
    check_dump("after_rst", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
